// File: rtl/pong_pkg.sv
// pong_pkg: shared constants and types for the pong game-logic stage and the
// VGA stage that rasterises its bounding boxes.
//   - Screen size and coordinate widths (WRES_BITS / HRES_BITS).
//   - Paddle and ball geometry, derived reset / centre / clamp positions.
//   - Game FSM state enum.
package pong_pkg;

    // Screen
    localparam int VGA_W     = 400;
    localparam int VGA_H     = 600;
    localparam int WRES_BITS = $clog2(VGA_W);   // 9
    localparam int HRES_BITS = $clog2(VGA_H);   // 10

    // Geometry and motion
    localparam int PADDLE_W        = 8;
    localparam int PADDLE_H        = 80;
    localparam int PADDLE_X_OFFSET = 16;
    localparam int BALL_SIZE       = 8;
    localparam int PADDLE_SPEED    = 6;
    localparam int BALL_SPEED      = 3;
    localparam int SERVE_FRAMES    = 60;
    localparam int MAX_SCORE       = 9;

    // Derived paddle positions
    localparam int PADL_XMIN   = PADDLE_X_OFFSET;                       // 16
    localparam int PADR_XMIN   = VGA_W - PADDLE_X_OFFSET - PADDLE_W;    // 376
    localparam int PAD_Y_RST   = (VGA_H - PADDLE_H) / 2;                // 260

    // Derived ball positions
    localparam int BALL_X_CTR   = (VGA_W - BALL_SIZE) / 2;              // 196
    localparam int BALL_Y_CTR   = (VGA_H - BALL_SIZE) / 2;              // 296
    localparam int BALL_X_LIMIT = VGA_W - BALL_SIZE;                    // 392
    localparam int BALL_Y_LIMIT = VGA_H - BALL_SIZE;                    // 592
    // Ball xmin when resting flush against each paddle's inner face
    localparam int BALL_HIT_L   = PADL_XMIN + PADDLE_W;                 // 24
    localparam int BALL_HIT_R   = PADR_XMIN - BALL_SIZE;                // 368

    // Register widths
    localparam int SPEED_BITS = 4;
    localparam int SERVE_BITS = $clog2(SERVE_FRAMES);
    localparam int SCORE_BITS = 4;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

endpackage

// File: rtl/pong_if.sv
// pong_if: bundle between the pong engine and its surroundings.
//   master (engine): takes frame_tick and the four buttons, drives paddle and
//                    ball bounding boxes, scores, point pulses and game_over.
//   slave  (VGA stage / controller): the mirror image.
interface pong_if;
    import pong_pkg::*;

    logic                  frame_tick;
    logic                  btn_left_up;
    logic                  btn_left_dn;
    logic                  btn_right_up;
    logic                  btn_right_dn;

    logic [WRES_BITS-1:0]  paddleleft_xmin;
    logic [WRES_BITS-1:0]  paddleleft_xmax;
    logic [WRES_BITS-1:0]  paddleright_xmin;
    logic [WRES_BITS-1:0]  paddleright_xmax;
    logic [WRES_BITS-1:0]  ball_xmin;
    logic [WRES_BITS-1:0]  ball_xmax;

    logic [HRES_BITS-1:0]  paddleleft_ymin;
    logic [HRES_BITS-1:0]  paddleleft_ymax;
    logic [HRES_BITS-1:0]  paddleright_ymin;
    logic [HRES_BITS-1:0]  paddleright_ymax;
    logic [HRES_BITS-1:0]  ball_ymin;
    logic [HRES_BITS-1:0]  ball_ymax;

    logic [SCORE_BITS-1:0] score_left;
    logic [SCORE_BITS-1:0] score_right;
    logic                  point_left;
    logic                  point_right;
    logic                  game_over;

    modport master (
        input  frame_tick, btn_left_up, btn_left_dn, btn_right_up, btn_right_dn,
        output paddleleft_xmin, paddleleft_xmax, paddleright_xmin, paddleright_xmax,
        output ball_xmin, ball_xmax,
        output paddleleft_ymin, paddleleft_ymax, paddleright_ymin, paddleright_ymax,
        output ball_ymin, ball_ymax,
        output score_left, score_right, point_left, point_right, game_over
    );

    modport slave (
        output frame_tick, btn_left_up, btn_left_dn, btn_right_up, btn_right_dn,
        input  paddleleft_xmin, paddleleft_xmax, paddleright_xmin, paddleright_xmax,
        input  ball_xmin, ball_xmax,
        input  paddleleft_ymin, paddleleft_ymax, paddleright_ymin, paddleright_ymax,
        input  ball_ymin, ball_ymax,
        input  score_left, score_right, point_left, point_right, game_over
    );

endinterface

// File: rtl/pong_paddle.sv
// pong_paddle: vertical position of one paddle.
//   Ports: clk, rst (sync, active-high), tick (frame pulse), up, dn (held
//   buttons); ymin / ymax registered inclusive vertical bounds.
//   One press direction moves SPEED lines per tick, saturating at the top (0)
//   and bottom (VGA_H - HEIGHT); both or neither pressed holds position.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int SPEED  = PADDLE_SPEED,
    parameter int HEIGHT = PADDLE_H,
    parameter int RST_Y  = PAD_Y_RST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 up,
    input  logic                 dn,
    output logic [HRES_BITS-1:0] ymin,
    output logic [HRES_BITS-1:0] ymax
);

    localparam logic [HRES_BITS-1:0] STEP    = HRES_BITS'(SPEED);
    localparam logic [HRES_BITS-1:0] Y_LIMIT = HRES_BITS'(VGA_H - HEIGHT);
    // Highest ymin from which a full downward step still fits
    localparam logic [HRES_BITS-1:0] DN_THR  = HRES_BITS'(VGA_H - HEIGHT - SPEED);
    localparam logic [HRES_BITS-1:0] SIZE_M1 = HRES_BITS'(HEIGHT - 1);
    localparam logic [HRES_BITS-1:0] Y_RST   = HRES_BITS'(RST_Y);

    logic [HRES_BITS-1:0] ymin_next;

    always_comb begin
        ymin_next = ymin;
        if (tick && up && !dn) begin
            ymin_next = (ymin < STEP) ? '0 : ymin - STEP;
        end else if (tick && dn && !up) begin
            ymin_next = (ymin > DN_THR) ? Y_LIMIT : ymin + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ymin <= Y_RST;
            ymax <= Y_RST + SIZE_M1;
        end else begin
            ymin <= ymin_next;
            ymax <= ymin_next + SIZE_M1;
        end
    end

endmodule

// File: rtl/pong_engine.sv
// pong_engine: pong game logic, one game step per frame_tick.
//   Ports: clk, rst (sync, active-high, wins over frame_tick);
//          bus (pong_if.master): frame_tick and buttons in; paddle / ball
//          bounding boxes, saturating scores, point pulses, game_over out.
//   FSM: SERVE (ball centred for SERVE_FRAMES ticks) -> PLAY (ball moves,
//   bounces, hits paddles or scores) -> SERVE, or GAME_OVER once a score
//   reaches MAX_SCORE. GAME_OVER is left only through rst.
//   Optional build macro PONG_SPEEDUP_EN: horizontal ball speed grows by one
//   per paddle hit up to 2*BALL_SPEED and is restored on every serve.
module pong_engine
    import pong_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    pong_if.master bus
);

    // Widened signed coordinates so a step past either edge cannot wrap
    localparam int XW = WRES_BITS + 2;
    localparam int YW = HRES_BITS + 2;

    localparam logic signed [XW-1:0] X_ZERO   = '0;
    localparam logic signed [XW-1:0] X_HIT_L  = XW'(BALL_HIT_L);
    localparam logic signed [XW-1:0] X_HIT_R  = XW'(BALL_HIT_R);
    localparam logic signed [XW-1:0] X_LIMIT  = XW'(BALL_X_LIMIT);
    localparam logic signed [YW-1:0] Y_ZERO   = '0;
    localparam logic signed [YW-1:0] Y_LIMIT  = YW'(BALL_Y_LIMIT);
    localparam logic signed [YW-1:0] Y_STEP   = YW'(BALL_SPEED);

    localparam logic [WRES_BITS-1:0]  BX_CTR    = WRES_BITS'(BALL_X_CTR);
    localparam logic [HRES_BITS-1:0]  BY_CTR    = HRES_BITS'(BALL_Y_CTR);
    localparam logic [WRES_BITS-1:0]  BX_HIT_L  = WRES_BITS'(BALL_HIT_L);
    localparam logic [WRES_BITS-1:0]  BX_HIT_R  = WRES_BITS'(BALL_HIT_R);
    localparam logic [HRES_BITS-1:0]  BY_LIMIT  = HRES_BITS'(BALL_Y_LIMIT);
    localparam logic [WRES_BITS-1:0]  BX_M1     = WRES_BITS'(BALL_SIZE - 1);
    localparam logic [HRES_BITS-1:0]  BY_M1     = HRES_BITS'(BALL_SIZE - 1);
    localparam logic [SERVE_BITS-1:0] SERVE_END = SERVE_BITS'(SERVE_FRAMES - 1);
    localparam logic [SCORE_BITS-1:0] SCORE_MAX = SCORE_BITS'(MAX_SCORE);
    localparam logic [SPEED_BITS-1:0] HSPD_BASE = SPEED_BITS'(BALL_SPEED);

    // Score increment that never passes MAX_SCORE
    function automatic logic [SCORE_BITS-1:0] score_inc(input logic [SCORE_BITS-1:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 1'b1;
    endfunction

    state_t                state, state_next;
    logic [SERVE_BITS-1:0] serve_cnt, serve_cnt_next;
    logic [WRES_BITS-1:0]  ball_x, ball_x_next, ball_xmax;
    logic [HRES_BITS-1:0]  ball_y, ball_y_next, ball_ymax;
    logic                  dx, dx_next;    // 1 = moving right
    logic                  dy, dy_next;    // 1 = moving down
    logic [SCORE_BITS-1:0] score_l, score_l_next, score_r, score_r_next;
    logic                  point_l, point_l_next, point_r, point_r_next;
    logic [SPEED_BITS-1:0] hspd;

`ifdef PONG_SPEEDUP_EN
    localparam logic [SPEED_BITS-1:0] HSPD_MAX = SPEED_BITS'(2 * BALL_SPEED);

    function automatic logic [SPEED_BITS-1:0] hspd_inc(input logic [SPEED_BITS-1:0] s);
        return (s >= HSPD_MAX) ? HSPD_MAX : s + 1'b1;
    endfunction

    logic [SPEED_BITS-1:0] hspd_next;
`else
    assign hspd = HSPD_BASE;
`endif

    logic [HRES_BITS-1:0] padl_ymin, padl_ymax, padr_ymin, padr_ymax;

    pong_paddle #(
        .SPEED  (PADDLE_SPEED),
        .HEIGHT (PADDLE_H),
        .RST_Y  (PAD_Y_RST)
    ) u_paddle_left (
        .clk  (clk),
        .rst  (rst),
        .tick (bus.frame_tick),
        .up   (bus.btn_left_up),
        .dn   (bus.btn_left_dn),
        .ymin (padl_ymin),
        .ymax (padl_ymax)
    );

    pong_paddle #(
        .SPEED  (PADDLE_SPEED),
        .HEIGHT (PADDLE_H),
        .RST_Y  (PAD_Y_RST)
    ) u_paddle_right (
        .clk  (clk),
        .rst  (rst),
        .tick (bus.frame_tick),
        .up   (bus.btn_right_up),
        .dn   (bus.btn_right_dn),
        .ymin (padr_ymin),
        .ymax (padr_ymax)
    );

    // Candidate ball step for PLAY: next position, bounce, hit and miss flags
    logic signed [XW-1:0] cur_x, step_x, nx;
    logic signed [YW-1:0] cur_y, ny;
    logic [HRES_BITS-1:0] by_play;
    logic                 dy_play;
    logic                 overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

    always_comb begin
        cur_x  = signed'({2'b00, ball_x});
        step_x = signed'({{(XW - SPEED_BITS){1'b0}}, hspd});
        nx     = dx ? cur_x + step_x : cur_x - step_x;
        cur_y  = signed'({2'b00, ball_y});
        ny     = dy ? cur_y + Y_STEP : cur_y - Y_STEP;

        by_play = ny[HRES_BITS-1:0];
        dy_play = dy;
        if (ny < Y_ZERO) begin
            by_play = '0;
            dy_play = 1'b1;
        end else if (ny > Y_LIMIT) begin
            by_play = BY_LIMIT;
            dy_play = 1'b0;
        end

        overlap_l = (ball_y <= padl_ymax) && (ball_ymax >= padl_ymin);
        overlap_r = (ball_y <= padr_ymax) && (ball_ymax >= padr_ymin);
        // A hit needs the ball to start on the court side of the face, so a
        // ball that already slipped past a paddle cannot be batted back.
        hit_l  = !dx && (cur_x >= X_HIT_L) && (nx <= X_HIT_L) && overlap_l;
        hit_r  =  dx && (cur_x <= X_HIT_R) && (nx >= X_HIT_R) && overlap_r;
        miss_r = !hit_l && !hit_r && (nx <= X_ZERO);    // right side scores
        miss_l = !hit_l && !hit_r && (nx >= X_LIMIT);   // left side scores
    end

    // FSM next-state and game update
    always_comb begin
        state_next     = state;
        serve_cnt_next = serve_cnt;
        ball_x_next    = ball_x;
        ball_y_next    = ball_y;
        dx_next        = dx;
        dy_next        = dy;
        score_l_next   = score_l;
        score_r_next   = score_r;
        point_l_next   = 1'b0;
        point_r_next   = 1'b0;
`ifdef PONG_SPEEDUP_EN
        hspd_next      = hspd;
`endif

        if (bus.frame_tick) begin
            case (state)
                ST_SERVE: begin
                    ball_x_next = BX_CTR;
                    ball_y_next = BY_CTR;
                    if (serve_cnt == SERVE_END) begin
                        serve_cnt_next = '0;
                        state_next     = ST_PLAY;
`ifdef PONG_SPEEDUP_EN
                        hspd_next      = HSPD_BASE;
`endif
                    end else begin
                        serve_cnt_next = serve_cnt + 1'b1;
                    end
                end

                ST_PLAY: begin
                    ball_y_next = by_play;
                    dy_next     = dy_play;
                    if (hit_l) begin
                        ball_x_next = BX_HIT_L;
                        dx_next     = 1'b1;
`ifdef PONG_SPEEDUP_EN
                        hspd_next   = hspd_inc(hspd);
`endif
                    end else if (hit_r) begin
                        ball_x_next = BX_HIT_R;
                        dx_next     = 1'b0;
`ifdef PONG_SPEEDUP_EN
                        hspd_next   = hspd_inc(hspd);
`endif
                    end else if (miss_r || miss_l) begin
                        ball_x_next = BX_CTR;
                        ball_y_next = BY_CTR;
                        dy_next     = ~dy_play;
                        // Next serve heads toward the side that conceded
                        dx_next     = miss_l;
`ifdef PONG_SPEEDUP_EN
                        hspd_next   = HSPD_BASE;
`endif
                        if (miss_r) begin
                            score_r_next = score_inc(score_r);
                            point_r_next = 1'b1;
                        end else begin
                            score_l_next = score_inc(score_l);
                            point_l_next = 1'b1;
                        end
                        state_next = ((score_l_next == SCORE_MAX) || (score_r_next == SCORE_MAX))
                                     ? ST_GAME_OVER : ST_SERVE;
                    end else begin
                        ball_x_next = nx[WRES_BITS-1:0];
                    end
                end

                ST_GAME_OVER: begin
                    ball_x_next = BX_CTR;
                    ball_y_next = BY_CTR;
                end

                default: begin
                    state_next = ST_SERVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SERVE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            serve_cnt <= '0;
            ball_x    <= BX_CTR;
            ball_xmax <= BX_CTR + BX_M1;
            ball_y    <= BY_CTR;
            ball_ymax <= BY_CTR + BY_M1;
            dx        <= 1'b1;
            dy        <= 1'b1;
            score_l   <= '0;
            score_r   <= '0;
            point_l   <= 1'b0;
            point_r   <= 1'b0;
        end else begin
            serve_cnt <= serve_cnt_next;
            ball_x    <= ball_x_next;
            ball_xmax <= ball_x_next + BX_M1;
            ball_y    <= ball_y_next;
            ball_ymax <= ball_y_next + BY_M1;
            dx        <= dx_next;
            dy        <= dy_next;
            score_l   <= score_l_next;
            score_r   <= score_r_next;
            point_l   <= point_l_next;
            point_r   <= point_r_next;
        end
    end

`ifdef PONG_SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hspd <= HSPD_BASE;
        end else begin
            hspd <= hspd_next;
        end
    end
`endif

    // Paddle columns never move
    assign bus.paddleleft_xmin  = WRES_BITS'(PADL_XMIN);
    assign bus.paddleleft_xmax  = WRES_BITS'(PADL_XMIN + PADDLE_W - 1);
    assign bus.paddleright_xmin = WRES_BITS'(PADR_XMIN);
    assign bus.paddleright_xmax = WRES_BITS'(PADR_XMIN + PADDLE_W - 1);
    assign bus.paddleleft_ymin  = padl_ymin;
    assign bus.paddleleft_ymax  = padl_ymax;
    assign bus.paddleright_ymin = padr_ymin;
    assign bus.paddleright_ymax = padr_ymax;
    assign bus.ball_xmin        = ball_x;
    assign bus.ball_xmax        = ball_xmax;
    assign bus.ball_ymin        = ball_y;
    assign bus.ball_ymax        = ball_ymax;
    assign bus.score_left       = score_l;
    assign bus.score_right      = score_r;
    assign bus.point_left       = point_l;
    assign bus.point_right      = point_r;
    assign bus.game_over        = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed bench for pong_engine. A vector table covers reset,
// paddle motion and saturation and the serve delay; hand-written sequences
// cover a paddle hit, a miss with its point pulse, game over and rst+tick.
module tb_pong_engine;
    import pong_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pong_if bus();

    pong_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit       do_rst;
        bit [3:0] btn;      // {left_up, left_dn, right_up, right_dn}
        int       ticks;
        int       pl;       // expected paddleleft_ymin
        int       pr;       // expected paddleright_ymin
        int       bx;       // expected ball_xmin
        int       by;       // expected ball_ymin
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_btn(input logic [3:0] b);
        bus.btn_left_up  = b[3];
        bus.btn_left_dn  = b[2];
        bus.btn_right_up = b[1];
        bus.btn_right_dn = b[0];
    endtask

    // One frame: tick high for exactly one rising edge, return at the
    // following falling edge with the updated outputs settled.
    task automatic tick();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pl_xmin"}, int'(bus.paddleleft_xmin), 16);
        chk({tag, "_pl_xmax"}, int'(bus.paddleleft_xmax), 23);
        chk({tag, "_pr_xmin"}, int'(bus.paddleright_xmin), 376);
        chk({tag, "_pr_xmax"}, int'(bus.paddleright_xmax), 383);
        chk({tag, "_pl_ymin"}, int'(bus.paddleleft_ymin), 260);
        chk({tag, "_pl_ymax"}, int'(bus.paddleleft_ymax), 339);
        chk({tag, "_pr_ymin"}, int'(bus.paddleright_ymin), 260);
        chk({tag, "_pr_ymax"}, int'(bus.paddleright_ymax), 339);
        chk({tag, "_b_xmin"}, int'(bus.ball_xmin), 196);
        chk({tag, "_b_xmax"}, int'(bus.ball_xmax), 203);
        chk({tag, "_b_ymin"}, int'(bus.ball_ymin), 296);
        chk({tag, "_b_ymax"}, int'(bus.ball_ymax), 303);
        chk({tag, "_score_l"}, int'(bus.score_left), 0);
        chk({tag, "_score_r"}, int'(bus.score_right), 0);
        chk({tag, "_point_l"}, int'(bus.point_left), 0);
        chk({tag, "_point_r"}, int'(bus.point_right), 0);
        chk({tag, "_game_over"}, int'(bus.game_over), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "tb_pong_engine timeout");
    end

    initial begin
        int exp_x;
        int got;
        int pulses;

        bus.frame_tick = 1'b0;
        set_btn(4'b0000);

        // Cumulative vectors: paddle motion/saturation and the 60-tick serve
        vecs[0] = '{1'b1, 4'b0000,  0, 260, 260, 196, 296};
        vecs[1] = '{1'b0, 4'b1000,  1, 254, 260, 196, 296};
        vecs[2] = '{1'b0, 4'b1000,  1, 248, 260, 196, 296};
        vecs[3] = '{1'b0, 4'b1000,  1, 242, 260, 196, 296};
        vecs[4] = '{1'b0, 4'b1100,  2, 242, 260, 196, 296};
        vecs[5] = '{1'b0, 4'b0001, 50, 242, 520, 196, 296};
        vecs[6] = '{1'b0, 4'b0010,  5, 242, 490, 196, 296};  // 60th tick: enters PLAY
        vecs[7] = '{1'b0, 4'b0000,  1, 242, 490, 199, 299};  // first PLAY step

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_rst) do_reset();
            set_btn(vecs[i].btn);
            ticks(vecs[i].ticks);
            chk($sformatf("v%0d_pl_ymin", i), int'(bus.paddleleft_ymin), vecs[i].pl);
            chk($sformatf("v%0d_pl_ymax", i), int'(bus.paddleleft_ymax), vecs[i].pl + 79);
            chk($sformatf("v%0d_pr_ymin", i), int'(bus.paddleright_ymin), vecs[i].pr);
            chk($sformatf("v%0d_pr_ymax", i), int'(bus.paddleright_ymax), vecs[i].pr + 79);
            chk($sformatf("v%0d_b_xmin", i), int'(bus.ball_xmin), vecs[i].bx);
            chk($sformatf("v%0d_b_xmax", i), int'(bus.ball_xmax), vecs[i].bx + 7);
            chk($sformatf("v%0d_b_ymin", i), int'(bus.ball_ymin), vecs[i].by);
            chk($sformatf("v%0d_b_ymax", i), int'(bus.ball_ymax), vecs[i].by + 7);
            if (i == 0) chk_reset_state("v0");
        end

        // Right paddle held up from mid-screen saturates at the top
        do_reset();
        set_btn(4'b0010);
        ticks(50);
        chk("pr_sat_top_ymin", int'(bus.paddleright_ymin), 0);
        chk("pr_sat_top_ymax", int'(bus.paddleright_ymax), 79);

        // Paddle hit: right paddle moved to 392..471 during the serve so the
        // ball (y 467..474 on the approach) meets it at step 58.
        do_reset();
        set_btn(4'b0001);
        ticks(22);
        set_btn(4'b0000);
        ticks(38);
        chk("hit_pr_ymin", int'(bus.paddleright_ymin), 392);
        ticks(57);
        chk("hit_pre_x", int'(bus.ball_xmin), 367);
        chk("hit_pre_y", int'(bus.ball_ymin), 467);
        tick();
        chk("hit_clamp_x", int'(bus.ball_xmin), 368);
        chk("hit_clamp_xmax", int'(bus.ball_xmax), 375);
        chk("hit_y", int'(bus.ball_ymin), 470);
        tick();
`ifdef PONG_SPEEDUP_EN
        exp_x = 364;
`else
        exp_x = 365;
`endif
        chk("hit_return_x", int'(bus.ball_xmin), exp_x);
        chk("hit_return_y", int'(bus.ball_ymin), 473);

        // Miss on the right: right paddle parked at the top
        do_reset();
        set_btn(4'b0010);
        ticks(60);
        ticks(65);
        chk("miss_pre_x", int'(bus.ball_xmin), 391);
        chk("miss_pre_point", int'(bus.point_left), 0);
        tick();
        chk("miss_point_l", int'(bus.point_left), 1);
        chk("miss_point_r", int'(bus.point_right), 0);
        chk("miss_score_l", int'(bus.score_left), 1);
        chk("miss_score_r", int'(bus.score_right), 0);
        chk("miss_recentre_x", int'(bus.ball_xmin), 196);
        chk("miss_recentre_y", int'(bus.ball_ymin), 296);
        @(negedge clk);
        chk("miss_point_clears", int'(bus.point_left), 0);
        ticks(59);
        chk("serve59_x", int'(bus.ball_xmin), 196);
        tick();
        chk("serve60_x", int'(bus.ball_xmin), 196);
        chk("serve60_y", int'(bus.ball_ymin), 296);
        tick();
        chk("reserve_x", int'(bus.ball_xmin), 199);
        chk("reserve_y_up", int'(bus.ball_ymin), 293);

        // Game over after nine left points
        do_reset();
        set_btn(4'b0010);
        for (int p = 1; p <= 9; p++) begin
            got = 0;
            for (int n = 0; n < 200 && got == 0; n++) begin
                tick();
                if (bus.point_left) got = 1;
            end
            chk($sformatf("point_%0d_arrives", p), got, 1);
            if (p == 8) chk("go_not_yet", int'(bus.game_over), 0);
        end
        chk("go_flag", int'(bus.game_over), 1);
        chk("go_score_l", int'(bus.score_left), 9);
        chk("go_score_r", int'(bus.score_right), 0);
        pulses = 0;
        for (int n = 0; n < 150; n++) begin
            tick();
            if (bus.point_left || bus.point_right) pulses++;
        end
        chk("go_no_more_points", pulses, 0);
        chk("go_score_hold", int'(bus.score_left), 9);
        chk("go_ball_x", int'(bus.ball_xmin), 196);
        chk("go_ball_y", int'(bus.ball_ymin), 296);
        chk("go_still_over", int'(bus.game_over), 1);
        set_btn(4'b0100);
        tick();
        chk("go_paddle_moves", int'(bus.paddleleft_ymin), 266);

        // rst in the same cycle as frame_tick wins
        set_btn(4'b1010);
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        set_btn(4'b0000);
        chk_reset_state("rst_tick");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
